// File: rtl/exp1_pkg.sv
// Shared types and constants for the exp1 sweep sequencer: FSM states,
// result_data field layout and the sweep vector count.
package exp1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } seq_state_e;

  localparam int unsigned OBS_W    = 5;
  localparam int unsigned ABC_W    = 3;
  localparam int unsigned SUB_W    = 2;
  localparam int unsigned TASK_W   = 1;
  localparam int unsigned OBS_OFF  = 0;
  localparam int unsigned ABC_OFF  = OBS_OFF + OBS_W;
  localparam int unsigned SUB_OFF  = ABC_OFF + ABC_W;
  localparam int unsigned TASK_OFF = SUB_OFF + SUB_W;
  localparam int unsigned RESULT_W = TASK_OFF + TASK_W;

  localparam int unsigned ABC_COUNT  = 8;
  localparam int unsigned TASK_COUNT = 2;

  typedef struct packed {
    logic             mode_task;
    logic [SUB_W-1:0] mode_subtask;
    logic [ABC_W-1:0] abc;
  } vec_t;

  function automatic int unsigned vector_count(input int unsigned subtask_max);
    return ABC_COUNT * (subtask_max + 1) * TASK_COUNT;
  endfunction

endpackage

// File: rtl/exp1_sequencer_if.sv
// Control, stimulus and observation signals between the exp1 sequencer and
// its datapath/controller. signature exists only with EXP1_SEQ_SIGNATURE_EN.
interface exp1_sequencer_if;
  import exp1_pkg::*;

  logic                start;
  logic                abort;
  logic                pause;
  logic                obs_l1;
  logic                obs_l2;
  logic                obs_x;
  logic                obs_y;
  logic                obs_z;
  logic                mode_task;
  logic [SUB_W-1:0]    mode_subtask;
  logic                signal_a;
  logic                signal_b;
  logic                signal_c;
  logic                result_valid;
  logic [RESULT_W-1:0] result_data;
  logic                busy;
  logic                done;
`ifdef EXP1_SEQ_SIGNATURE_EN
  logic [7:0]          signature;
`endif

  modport slave (
`ifdef EXP1_SEQ_SIGNATURE_EN
    output signature,
`endif
    input  start, abort, pause,
    input  obs_l1, obs_l2, obs_x, obs_y, obs_z,
    output mode_task, mode_subtask, signal_a, signal_b, signal_c,
    output result_valid, result_data, busy, done
  );

  modport master (
`ifdef EXP1_SEQ_SIGNATURE_EN
    input  signature,
`endif
    output start, abort, pause,
    output obs_l1, obs_l2, obs_x, obs_y, obs_z,
    input  mode_task, mode_subtask, signal_a, signal_b, signal_c,
    input  result_valid, result_data, busy, done
  );

endinterface

// File: rtl/exp1_dwell_timer.sv
// Settle-cycle counter: counts enabled cycles and flags the last settle cycle.
module exp1_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(DWELL_CYCLES - 1);

  logic [7:0] count_q;

  // Saturates on the last settle cycle; the owner clears it on every advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/exp1_sequencer.sv
// Sweeps {task, subtask, abc} over the exp1 datapath, settling each vector
// and strobing out the observed result. Optional: EXP1_SEQ_SIGNATURE_EN.
module exp1_sequencer
  import exp1_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned SUBTASK_MAX  = 3
) (
  input  logic clk,
  input  logic rst_n,
  exp1_sequencer_if.slave bus
);

  localparam int unsigned    NUM_VECTORS = vector_count(SUBTASK_MAX);
  localparam logic [5:0]     LAST_IDX    = 6'(NUM_VECTORS - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SUBTASK_MAX);

  seq_state_e state_q;
  vec_t       vec_q;
  vec_t       vec_d;
  logic [5:0] idx_q;

  logic             capture_go;
  logic             launch;
  logic             timer_en;
  logic             timer_clear;
  logic             expired;
  logic [OBS_W-1:0] obs;

  assign obs = {bus.obs_l1, bus.obs_l2, bus.obs_x, bus.obs_y, bus.obs_z};

  // The strobe must vanish in the very cycle abort or pause is raised, so it
  // is decoded from the registered state rather than registered itself.
  assign capture_go  = (state_q == ST_CAPTURE) && !bus.pause && !bus.abort;
  assign launch      = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start && !bus.abort;
  assign timer_en    = (state_q == ST_SETTLE) && !bus.pause && !bus.abort;
  assign timer_clear = bus.abort || capture_go || launch;

  exp1_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin
    vec_d = vec_q;
    if (vec_q.abc == '1) begin
      vec_d.abc = '0;
      if (vec_q.mode_subtask == SUB_LAST) begin
        vec_d.mode_subtask = '0;
        vec_d.mode_task    = ~vec_q.mode_task;
      end else begin
        vec_d.mode_subtask = vec_q.mode_subtask + 2'd1;
      end
    end else begin
      vec_d.abc = vec_q.abc + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
    end else if (bus.abort) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q <= ST_SETTLE;
            vec_q   <= '0;
            idx_q   <= '0;
          end
        end
        ST_SETTLE: begin
          if (!bus.pause && expired) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!bus.pause) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SETTLE;
              vec_q   <= vec_d;
              idx_q   <= idx_q + 6'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mode_task    = vec_q.mode_task;
  assign bus.mode_subtask = vec_q.mode_subtask;
  assign bus.signal_a     = vec_q.abc[2];
  assign bus.signal_b     = vec_q.abc[1];
  assign bus.signal_c     = vec_q.abc[0];
  assign bus.busy         = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.result_valid = capture_go;

  always_comb begin
    bus.result_data = '0;
    bus.result_data[TASK_OFF +: TASK_W] = vec_q.mode_task;
    bus.result_data[SUB_OFF  +: SUB_W]  = vec_q.mode_subtask;
    bus.result_data[ABC_OFF  +: ABC_W]  = vec_q.abc;
    bus.result_data[OBS_OFF  +: OBS_W]  = obs;
  end

`ifdef EXP1_SEQ_SIGNATURE_EN
  logic [7:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (launch) begin
      sig_q <= '0;
    end else if (capture_go) begin
      sig_q <= {sig_q[6:0], sig_q[7]} ^ {3'b000, obs};
    end
  end

  assign bus.signature = sig_q;
`endif

endmodule

// File: tb/tb_exp1_sequencer.sv
// Randomised bench for exp1_sequencer against a sweep-index reference model,
// plus directed sweeps for latency, pause, abort, restart and signature.
module tb_exp1_sequencer;

  localparam int D  = 4;
  localparam int SM = 3;
  localparam int N  = 8 * (SM + 1) * 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  exp1_sequencer_if ifc ();

  exp1_sequencer #(
    .DWELL_CYCLES (D),
    .SUBTASK_MAX  (SM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sweep position as an index plus cycles spent on it.
  int         m_run  = 0;
  int         m_done = 0;
  int         m_idx  = 0;
  int         m_ph   = 0;
  logic [7:0] m_sig  = 8'h00;

  int          obs_mode = 0;
  logic        dut_rv;
  logic [10:0] dut_data;
  int          n_strobe, n_v5, n_pstrobe;

  function automatic logic [5:0] vec6(input int idx);
    int abc, sub, tk;
    abc = idx % 8;
    sub = (idx / 8) % (SM + 1);
    tk  = idx / (8 * (SM + 1));
    return {tk[0], sub[1:0], abc[2:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit st, input bit ab, input bit pa);
    logic [5:0]  ev;
    logic [4:0]  ob;
    logic        erv;
    @(negedge clk);
    ev = (m_run != 0) ? vec6(m_idx) : ((m_done != 0) ? vec6(N - 1) : 6'd0);
    case (obs_mode)
      1:       ob = 5'b00000;
      2:       ob = {4'b0000, (m_run != 0 && m_idx == 0)};
      default: ob = {^ev[2:0], 4'($urandom_range(0, 15))};
    endcase
    ifc.start  = st;
    ifc.abort  = ab;
    ifc.pause  = pa;
    {ifc.obs_l1, ifc.obs_l2, ifc.obs_x, ifc.obs_y, ifc.obs_z} = ob;
    #2;
    erv      = (m_run != 0) && (m_ph == D) && !pa && !ab;
    dut_rv   = ifc.result_valid;
    dut_data = ifc.result_data;
    check("vector", {ifc.mode_task, ifc.mode_subtask, ifc.signal_a, ifc.signal_b, ifc.signal_c}, ev);
    check("busy", ifc.busy, m_run[0]);
    check("done", ifc.done, m_done[0]);
    check("result_valid", dut_rv, erv);
    if (erv) check("result_data", dut_data, {ev, ob});
`ifdef EXP1_SEQ_SIGNATURE_EN
    check("signature", ifc.signature, m_sig);
`endif
    if (dut_rv) begin
      n_strobe++;
      if (dut_data[10:5] == 6'd5) n_v5++;
      if (pa) n_pstrobe++;
    end
    if (ab) begin
      m_run = 0; m_done = 0; m_idx = 0; m_ph = 0;
    end else if (m_run == 0 && st) begin
      m_run = 1; m_done = 0; m_idx = 0; m_ph = 0; m_sig = 8'h00;
    end else if (m_run != 0 && !pa) begin
      if (m_ph < D) begin
        m_ph++;
      end else begin
        m_sig = {m_sig[6:0], m_sig[7]} ^ {3'b000, ob};
        if (m_idx == N - 1) begin
          m_run = 0; m_done = 1;
        end else begin
          m_idx++; m_ph = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.pause = 1'b0;
    #1;
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_vector", {ifc.mode_task, ifc.mode_subtask, ifc.signal_a, ifc.signal_b, ifc.signal_c}, 0);
    check("rst_valid", ifc.result_valid, 0);
`ifdef EXP1_SEQ_SIGNATURE_EN
    check("rst_signature", ifc.signature, 0);
`endif
    m_run = 0; m_done = 0; m_idx = 0; m_ph = 0; m_sig = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_sweep(input bit do_pause, input bit do_abort);
    int   lat, pleft;
    bit   st, pa, ab;
    logic [5:0] first_vec;
    n_strobe = 0; n_v5 = 0; n_pstrobe = 0;
    lat = -1; first_vec = 6'h3f;
    pleft = do_pause ? 10 : 0;
    cycle(1, 0, 0);
    for (int k = 1; k <= 2000 && m_run != 0; k++) begin
      pa = 0;
      if (pleft > 0 && (pleft < 10 || (m_idx == 5 && m_ph == 1))) begin
        pa = 1;
        pleft--;
      end
      ab = do_abort && m_idx == 10 && m_ph == D;
      st = ($urandom_range(0, 9) == 0);
      cycle(st, ab, pa);
      if (k == 1) check("start_clears_done", ifc.done, 0);
      if (dut_rv && lat < 0) begin
        lat = k;
        first_vec = dut_data[10:5];
      end
      if (ab) begin
        check("abort_no_strobe", dut_rv, 0);
        break;
      end
    end
    check("first_strobe_latency", lat, D + 1);
    check("first_strobe_vector", first_vec, 0);
    cycle(0, 0, 0);
    check("sweep_ended", ifc.busy, 0);
    if (do_abort) begin
      check("abort_done", ifc.done, 0);
      check("abort_vector", {ifc.mode_task, ifc.mode_subtask, ifc.signal_a, ifc.signal_b, ifc.signal_c}, 0);
      check("abort_strobes", n_strobe, 10);
    end else begin
      check("strobe_count", n_strobe, 64);
      check("done_after_sweep", ifc.done, 1);
      if (do_pause) begin
        check("v5_captures", n_v5, 1);
        check("paused_strobes", n_pstrobe, 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.pause = 1'b0;
    {ifc.obs_l1, ifc.obs_l2, ifc.obs_x, ifc.obs_y, ifc.obs_z} = 5'b0;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);

    obs_mode = 0;
    run_sweep(0, 0);
    run_sweep(1, 0);
    run_sweep(0, 1);
    run_sweep(0, 0);

    obs_mode = 1;
    run_sweep(0, 0);
`ifdef EXP1_SEQ_SIGNATURE_EN
    check("sig_all_zero", ifc.signature, 8'h00);
`endif
    obs_mode = 2;
    run_sweep(0, 0);
`ifdef EXP1_SEQ_SIGNATURE_EN
    check("sig_first_z", ifc.signature, 8'h80);
`endif

    obs_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exp1_sequencer.md
EXP1_SEQUENCER -- requirements
Module: exp1_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 4 (range 1..255): settle cycles held per input vector before capture.
REQ-002 Parameter SUBTASK_MAX, default 3 (range 0..3): highest mode_subtask value swept.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a sweep; ignored while busy=1.
REQ-006 abort  in  1  terminates the sweep in progress.
REQ-007 pause  in  1  level; freezes the sweep while high.
REQ-008 obs_l1, obs_l2, obs_x, obs_y, obs_z  in  1 each  observed outputs of the exp1 datapath.
REQ-009 mode_task  out  1, mode_subtask  out  2  datapath mode select, registered.
REQ-010 signal_a, signal_b, signal_c  out  1 each  datapath stimulus, registered.
REQ-011 result_valid  out  1  one-cycle capture strobe.
REQ-012 result_data  out  11  {mode_task, mode_subtask, a, b, c, l1, l2, x, y, z}, valid when result_valid=1.
REQ-013 busy  out  1, done  out  1  sweep active / sweep completed.

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE, CAPTURE and DONE.
REQ-015 IDLE: vector outputs=0, busy=0; start=1 -> load vector (task 0, subtask 0, abc 000), clear dwell counter, go to SETTLE.
REQ-016 Sweep order SHALL be abc 000..111 innermost, then subtask 0..SUBTASK_MAX, then task 0..1; default 64 vectors.
REQ-017 SETTLE SHALL count DWELL_CYCLES cycles with pause=0, then go to CAPTURE.
REQ-018 CAPTURE (pause=0): result_valid=1 for exactly one cycle, result_data = current vector plus the obs_* values sampled that cycle.
REQ-019 After CAPTURE: last vector -> DONE; otherwise advance the vector, clear the counter, go to SETTLE; per-vector period = DWELL_CYCLES+1 cycles.
REQ-020 First result_valid SHALL occur DWELL_CYCLES+1 cycles after the cycle in which start is sampled.
REQ-021 pause=1 SHALL hold the state, counter and vector and suppress result_valid; resume continues without loss or repeat.
REQ-022 DONE: done=1, busy=0, last vector held; start=1 -> clear done and begin a new sweep exactly as from IDLE.
REQ-023 abort=1 in any state SHALL force IDLE next cycle, zero the vector, clear done and suppress result_valid; abort beats start, pause and capture.
REQ-024 busy=1 exactly in SETTLE and CAPTURE.

Reset
REQ-025 rst_n=0 SHALL force IDLE, all outputs 0, counter 0 and signature 0 (when present), independent of clk.
REQ-026 Reset mid-sweep SHALL discard progress; the next start begins at vector 0.

Configuration
REQ-027 With EXP1_SEQ_SIGNATURE_EN defined, add output signature[7:0]: cleared on start; each CAPTURE updates sig <= {sig[6:0],sig[7]} ^ {3'b000,l1,l2,x,y,z}.
REQ-028 Without EXP1_SEQ_SIGNATURE_EN, the signature port and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package exp1_pkg SHALL hold the FSM state enum, the result_data field widths/offsets and the vector-count constant.
REQ-030 The dwell counter SHALL be a sub-module exp1_dwell_timer (inputs clear/enable, output expired).

Verification
REQ-031 Reset, then start with DWELL_CYCLES=4 -> first result_valid 5 cycles later with result_data[10:5]=000000; 64 strobes total, done=1 after the 64th.
REQ-032 obs_* tied to a model of abc parity -> each result_data[4:0] matches the model for its vector, in the order of REQ-016.
REQ-033 pause high for 10 cycles during SETTLE of vector 5 -> no strobe while paused; vector 5 captured once; total still 64.
REQ-034 abort asserted in the CAPTURE cycle of vector 10 -> no strobe that cycle; IDLE next cycle, outputs 0, done=0.
REQ-035 start pulsed while busy -> ignored, sweep sequence unchanged; start in DONE -> done clears and a new sweep begins at vector 0.
REQ-036 With EXP1_SEQ_SIGNATURE_EN and all obs_*=0 -> signature=0x00 at done; obs_z=1 only on the first vector -> signature equals 0x01 rotated left 63 times = 0x80.
